// File: rtl/button_front_end.sv
// Push-button conditioning: 2-flop sync and debounce per button, up/down press pulses,
// set short/long-press FSM. Define BUTTON_AUTO_REPEAT_EN to enable up/down auto-repeat.
module button_front_end #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set,
  input  logic btn_up,
  input  logic btn_down,
  output logic set,
  output logic up,
  output logic down,
  output logic clr,
  output logic held
);
  localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_PL  = (REPEAT_PERIOD > LONG_CYCLES) ? REPEAT_PERIOD : LONG_CYCLES;
  localparam int MAX_ALL = (MAX_DR > MAX_PL) ? MAX_DR : MAX_PL;
  localparam int CW      = $clog2(MAX_ALL) + 1;
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS, LONG} set_state_t;

  // Button vectors are ordered {down, up, set}.
  logic [2:0]    sync_p0, sync_p1, lvl_p2;
  logic [1:0]    lvl_p3;
  logic [CW-1:0] dcnt [3];
  logic [1:0]    pulse_p3;
  logic          conflict;
  set_state_t    state;
  logic [CW-1:0] hold;

  assign conflict = lvl_p2[1] & lvl_p2[2];
  assign up       = pulse_p3[0];
  assign down     = pulse_p3[1];

  // Stage p0/p1: synchronizer; p2: debounced level; p3: previous level for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      lvl_p2  <= '0;
      lvl_p3  <= '0;
      for (int i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      sync_p0 <= {btn_down, btn_up, btn_set};
      sync_p1 <= sync_p0;
      lvl_p3  <= lvl_p2[2:1];
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] != lvl_p2[i]) begin
          if (dcnt[i] == DB_LAST) begin
            lvl_p2[i] <= sync_p1[i];
            dcnt[i]   <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + CW'(1);
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CW-1:0] RPT_DELAY  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RPT_PERIOD = CW'(REPEAT_PERIOD);

  logic [CW-1:0] rpt [2];
  logic [1:0]    rpt_run;

  // rpt == 0 marks a fresh start: a real rise pulses now, a conflict release only re-arms.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt[0]   <= '0;
      rpt[1]   <= '0;
      rpt_run  <= '0;
      pulse_p3 <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (!lvl_p2[c+1] || conflict) begin
          rpt[c]      <= '0;
          rpt_run[c]  <= 1'b0;
          pulse_p3[c] <= 1'b0;
        end else if (rpt[c] == '0) begin
          rpt[c]      <= CW'(1);
          rpt_run[c]  <= 1'b0;
          pulse_p3[c] <= ~lvl_p3[c];
        end else if (rpt[c] == (rpt_run[c] ? RPT_PERIOD : RPT_DELAY)) begin
          rpt[c]      <= CW'(1);
          rpt_run[c]  <= 1'b1;
          pulse_p3[c] <= 1'b1;
        end else begin
          rpt[c]      <= (rpt[c] == '1) ? rpt[c] : rpt[c] + CW'(1);
          pulse_p3[c] <= 1'b0;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pulse_p3 <= '0;
    else        pulse_p3 <= lvl_p2[2:1] & ~lvl_p3 & {2{~conflict}};
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      hold  <= '0;
      set   <= 1'b0;
      clr   <= 1'b0;
      held  <= 1'b0;
    end else begin
      set  <= 1'b0;
      clr  <= 1'b0;
      held <= |lvl_p2;
      case (state)
        IDLE: if (lvl_p2[0]) begin
          state <= PRESS;
          hold  <= '0;
        end
        PRESS: if (!lvl_p2[0]) begin
          state <= IDLE;
          set   <= 1'b1;
        end else if (hold == LONG_LAST) begin
          state <= LONG;
          clr   <= 1'b1;
        end else begin
          hold <= hold + CW'(1);
        end
        LONG: if (!lvl_p2[0]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
